// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci test-pattern generator: FSM states and
// overflow-mode encodings.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_STOP    = 2'd1;
    localparam logic [1:0] MODE_RESTART = 2'd2;

    // Encoding 3 is reserved and behaves as wrap.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_WRAP : m;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Term-slot counter: a clock enable that pulses tick on the last cycle of each
// DECIMATION-cycle slot, counting only while en is high.
module tick_divider #(
    parameter int DECIMATION = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [CW-1:0] LAST = CW'(DECIMATION - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/fib_seq_gen.sv
// Parametrised Fibonacci term generator with programmable seeds, slot divider,
// three overflow policies, optional term limit and valid/ready output.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DECIMATION = 16,
    parameter int MAX_TERMS  = 0,
    parameter int IDX_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             overflow,
    output logic             busy
);

    localparam bit              LIMITED = (MAX_TERMS != 0);
    localparam logic [IDX_W-1:0] LIMIT  = IDX_W'(MAX_TERMS);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a, b, sa_q, sb_q;
    logic             b_c;
    logic [1:0]       mode_q;
    logic             load, tick, slot_en, accept, pending, stop_hit, last_acc;
    logic [WIDTH:0]   adv_sum, seed_sum;

    assign accept   = out_valid & out_ready;
    assign pending  = out_valid & ~out_ready;
    assign slot_en  = (state == RUN) && !pending;
    assign stop_hit = tick && b_c && (mode_q == MODE_STOP);
    assign last_acc = LIMITED && accept && (state == RUN) && ((out_index + 1'b1) == LIMIT);
    assign adv_sum  = {1'b0, a} + {1'b0, b};
    assign seed_sum = {1'b0, sa_q} + {1'b0, sb_q};
    assign busy     = (state == RUN);

    tick_divider #(.DECIMATION(DECIMATION)) u_div (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (slot_en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
                RUN: if (stop_hit || last_acc) state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a         <= '0;
            b         <= '0;
            b_c       <= 1'b0;
            sa_q      <= '0;
            sb_q      <= '0;
            mode_q    <= MODE_WRAP;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            overflow  <= 1'b0;
        end else begin
            // Restart-mode overflow is a single-cycle pulse; later writes win.
            if (mode_q == MODE_RESTART) overflow <= 1'b0;

            if (abort) begin
                out_valid <= 1'b0;
            end else if (load) begin
                sa_q      <= seed_a;
                sb_q      <= seed_b;
                mode_q    <= norm_mode(mode);
                a         <= seed_a;
                b         <= seed_b;
                b_c       <= 1'b0;
                out_index <= '0;
                overflow  <= 1'b0;
                out_valid <= 1'b0;
            end else if (state == RUN) begin
                if (accept) begin
                    out_index <= out_index + 1'b1;
                    out_valid <= 1'b0;
                end
                if (tick) begin
                    if (b_c && mode_q == MODE_STOP) begin
                        overflow <= 1'b1;
                    end else if (b_c && mode_q == MODE_RESTART) begin
                        out_data   <= sb_q;
                        out_valid  <= 1'b1;
                        a          <= sb_q;
                        {b_c, b}   <= seed_sum;
                        overflow   <= 1'b1;
                    end else begin
                        out_data   <= b;
                        out_valid  <= 1'b1;
                        a          <= b;
                        {b_c, b}   <= adv_sum;
                        if (b_c) overflow <= 1'b1;
                    end
                end
                // The limiting handshake ends the run; any term loaded alongside is dropped.
                if (last_acc) out_valid <= 1'b0;
            end
        end
    end

endmodule
